// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: register map, CTRL bit layout
// and the packed CTRL register view.
package timer_pkg;

    // Register select values on data_m_addr
    localparam logic REG_COUNT = 1'b0;
    localparam logic REG_CTRL  = 1'b1;

    // CTRL bit positions
    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_PERIODIC = 2;
    localparam int CTRL_EXPIRED  = 15;

    // CTRL as it appears on the bus; rsvd is never written and reads 0
    typedef struct packed {
        logic        expired;
        logic [11:0] rsvd;
        logic        periodic;
        logic        irq_en;
        logic        enable;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '0;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to the timer tick rate. Emits a one-cycle
// tick at the terminal count while enabled; held at zero while disabled.
module tick_prescaler #(
    parameter int unsigned clk_freq = 50000000,
    parameter int unsigned tick_hz  = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV   = clk_freq / tick_hz;
    localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == CNT_W'(DIV - 1));
    assign tick    = en & at_term;

    // Next count: clear on request, hold at 0 when disabled, wrap at terminal
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        if (clr || !en || at_term) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler count register with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_ports.sv
// Programmable interval timer as an I/O-port responder. Two registers:
// COUNT (reload/current count) and CTRL (enable, irq_en, periodic, expired).
// Read data is zero outside the ack cycle so it can be ORed onto a shared bus.
module timer_ports
    import timer_pkg::*;
#(
    parameter int unsigned clk_freq = 50000000,
    parameter int unsigned tick_hz  = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        data_m_addr,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    input  logic [1:0]  data_m_bytesel,
    input  logic        data_m_wr_en,
    output logic        data_m_ack,
    output logic        intr
);

    logic        ack_q,    ack_d;
    logic [15:0] rdata_q,  rdata_d;
    logic        intr_q,   intr_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q,  count_d;
    ctrl_t       ctrl_q,   ctrl_d;

    logic access;
    logic wr_count;
    logic wr_ctrl;
    logic presc_clr;
    logic tick;

    // A held cs is ignored in the cycle right after ack, giving one ack per access
    assign access   = cs & ~ack_q;
    assign wr_count = access & data_m_wr_en & (data_m_addr == REG_COUNT);
    assign wr_ctrl  = access & data_m_wr_en & (data_m_addr == REG_CTRL);

    tick_prescaler #(
        .clk_freq (clk_freq),
        .tick_hz  (tick_hz)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (ctrl_q.enable),
        .clr   (presc_clr),
        .tick  (tick)
    );

    // Next-state for bus handshake, registers and countdown, in priority order
    always_comb begin
        ack_d     = access;
        rdata_d   = '0;
        intr_d    = ctrl_q.expired & ctrl_q.irq_en;
        reload_d  = reload_q;
        count_d   = count_q;
        ctrl_d    = ctrl_q;
        presc_clr = 1'b0;

        if (access && !data_m_wr_en) begin
            rdata_d = (data_m_addr == REG_COUNT) ? count_q : ctrl_q;
        end

        // Software clear of expired comes first so a same-cycle expiry overrides it
        if (wr_ctrl && data_m_bytesel[1] && data_m_data_in[CTRL_EXPIRED]) begin
            ctrl_d.expired = 1'b0;
        end

        // Countdown; a COUNT write in the same cycle suppresses the tick entirely
        if (tick && ctrl_q.enable && !wr_count) begin
            if (count_q == 16'd1) begin
                ctrl_d.expired = 1'b1;
                if (ctrl_q.periodic) begin
                    count_d = reload_q;
                end else begin
                    count_d       = '0;
                    ctrl_d.enable = 1'b0;
                end
            end else begin
                // count 0 wraps to 0xFFFF, giving a 65536-tick period for reload 0
                count_d = count_q - 16'd1;
            end
        end

        // Control bits written last so software's enable value wins over expiry
        if (wr_ctrl && data_m_bytesel[0]) begin
            ctrl_d.enable   = data_m_data_in[CTRL_ENABLE];
            ctrl_d.irq_en   = data_m_data_in[CTRL_IRQ_EN];
            ctrl_d.periodic = data_m_data_in[CTRL_PERIODIC];
            if (data_m_data_in[CTRL_ENABLE] && !ctrl_q.enable) begin
                count_d   = reload_q;
                presc_clr = 1'b1;
            end
        end

        // COUNT write: byte-merge into reload, then restart the count from it
        if (wr_count) begin
            if (data_m_bytesel[0]) reload_d[7:0]  = data_m_data_in[7:0];
            if (data_m_bytesel[1]) reload_d[15:8] = data_m_data_in[15:8];
            count_d   = reload_d;
            presc_clr = 1'b1;
        end
    end

    // All architectural state, synchronously reset
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            intr_q   <= 1'b0;
            reload_q <= '0;
            count_q  <= '0;
            ctrl_q   <= CTRL_RESET;
        end else begin
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            intr_q   <= intr_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign data_m_ack      = ack_q;
    assign data_m_data_out = rdata_q;
    assign intr            = intr_q;

endmodule

// File: tb/tb_timer_ports.sv
// Directed bench for timer_ports with a 4-cycle tick (clk_freq/tick_hz = 4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_timer_ports;

    localparam int unsigned CLK_FREQ = 100;
    localparam int unsigned TICK_HZ  = 25;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        data_m_addr;
    logic [15:0] data_m_data_in;
    logic [15:0] data_m_data_out;
    logic [1:0]  data_m_bytesel;
    logic        data_m_wr_en;
    logic        data_m_ack;
    logic        intr;

    int checks = 0;
    int errors = 0;

    timer_ports #(
        .clk_freq (CLK_FREQ),
        .tick_hz  (TICK_HZ)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cs              (cs),
        .data_m_addr     (data_m_addr),
        .data_m_data_in  (data_m_data_in),
        .data_m_data_out (data_m_data_out),
        .data_m_bytesel  (data_m_bytesel),
        .data_m_wr_en    (data_m_wr_en),
        .data_m_ack      (data_m_ack),
        .intr            (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus access starting at a falling edge; returns one idle cycle after ack
    task automatic bus(input logic wr, input logic addr, input logic [1:0] be,
                       input logic [15:0] wdata, input string tag, output logic [15:0] rdata);
        int waited;
        cs             = 1'b1;
        data_m_wr_en   = wr;
        data_m_addr    = addr;
        data_m_bytesel = be;
        data_m_data_in = wdata;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!data_m_ack && waited < 4);
        check({tag, " ack_latency"}, 16'(waited), 16'd1);
        rdata = data_m_data_out;
        cs             = 1'b0;
        data_m_wr_en   = 1'b0;
        data_m_bytesel = 2'b00;
        data_m_data_in = '0;
        @(negedge clk);
        check({tag, " idle_ack"}, {15'd0, data_m_ack}, 16'd0);
        check({tag, " idle_dout"}, data_m_data_out, 16'h0000);
    endtask

    task automatic wr(input logic addr, input logic [1:0] be, input logic [15:0] wdata, input string tag);
        logic [15:0] rd_unused;
        bus(1'b1, addr, be, wdata, tag, rd_unused);
        check({tag, " wr_dout"}, rd_unused, 16'h0000);
    endtask

    task automatic rd(input logic addr, input logic [15:0] exp, input string tag);
        logic [15:0] got;
        bus(1'b0, addr, 2'b11, 16'h0000, tag, got);
        check({tag, " rdata"}, got, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        cs             = 1'b0;
        data_m_addr    = 1'b0;
        data_m_data_in = '0;
        data_m_bytesel = 2'b00;
        data_m_wr_en   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ack",  {15'd0, data_m_ack}, 16'd0);
        check("reset dout", data_m_data_out, 16'h0000);
        check("reset intr", {15'd0, intr}, 16'd0);
        reset = 1'b0;
        @(negedge clk);

        rd(1'b1, 16'h0000, "rst ctrl");
        rd(1'b0, 16'h0000, "rst count");

        // One-shot: count 3 with 4-cycle ticks expires 12 cycles after enable
        wr(1'b0, 2'b11, 16'h0003, "oneshot count");
        wr(1'b1, 2'b01, 16'h0003, "oneshot ctrl");
        repeat (11) @(negedge clk);
        check("oneshot intr before", {15'd0, intr}, 16'd0);
        @(negedge clk);
        check("oneshot intr rise", {15'd0, intr}, 16'd1);
        rd(1'b1, 16'h8002, "oneshot ctrl after");
        rd(1'b0, 16'h0000, "oneshot count after");

        wr(1'b1, 2'b10, 16'h8000, "clear expired");
        check("intr after clear", {15'd0, intr}, 16'd0);

        // Periodic: reload 2 expires 8 cycles after enable, then every 8 cycles
        wr(1'b0, 2'b11, 16'h0002, "per count");
        wr(1'b1, 2'b01, 16'h0007, "per ctrl");
        repeat (7) @(negedge clk);
        check("per intr before", {15'd0, intr}, 16'd0);
        @(negedge clk);
        check("per intr rise", {15'd0, intr}, 16'd1);
        rd(1'b0, 16'h0002, "per count reloaded");
        wr(1'b1, 2'b10, 16'h8000, "per clear");
        check("per intr cleared", {15'd0, intr}, 16'd0);
        repeat (3) @(negedge clk);
        check("per intr 2nd before", {15'd0, intr}, 16'd0);
        @(negedge clk);
        check("per intr 2nd rise", {15'd0, intr}, 16'd1);

        // Software clear lands on the same edge as the third expiry
        repeat (6) @(negedge clk);
        wr(1'b1, 2'b10, 16'h8000, "race clear");
        check("race intr held", {15'd0, intr}, 16'd1);
        rd(1'b1, 16'h8007, "race ctrl");

        wr(1'b1, 2'b01, 16'h0000, "disable");
        wr(1'b1, 2'b10, 16'h8000, "final clear");
        @(negedge clk);
        check("intr low after disable", {15'd0, intr}, 16'd0);

        // Byte-lane writes into reload
        wr(1'b0, 2'b11, 16'h1200, "byte base");
        wr(1'b0, 2'b01, 16'hAB55, "byte low");
        rd(1'b0, 16'h1255, "byte low result");
        wr(1'b0, 2'b10, 16'hCD00, "byte high");
        rd(1'b0, 16'hCD55, "byte high result");

        // Reload 0: first tick wraps count to 0xFFFF
        wr(1'b0, 2'b11, 16'h0000, "wrap count");
        wr(1'b1, 2'b01, 16'h0001, "wrap ctrl");
        repeat (3) @(negedge clk);
        rd(1'b0, 16'hFFFF, "wrap result");
        wr(1'b1, 2'b01, 16'h0000, "wrap disable");

        // COUNT write on the same edge as a tick: no decrement
        wr(1'b0, 2'b11, 16'h0010, "coll count");
        wr(1'b1, 2'b01, 16'h0001, "coll ctrl");
        repeat (6) @(negedge clk);
        wr(1'b0, 2'b11, 16'h0020, "coll write");
        rd(1'b0, 16'h0020, "coll result");
        wr(1'b1, 2'b01, 16'h0006, "pre-reset ctrl");

        // Reset asserted while a read is pending
        cs             = 1'b1;
        data_m_wr_en   = 1'b0;
        data_m_addr    = 1'b1;
        data_m_bytesel = 2'b11;
        reset          = 1'b1;
        @(negedge clk);
        check("rst mid ack",  {15'd0, data_m_ack}, 16'd0);
        check("rst mid dout", data_m_data_out, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("rst post ack",  {15'd0, data_m_ack}, 16'd1);
        check("rst post dout", data_m_data_out, 16'h0000);
        cs = 1'b0;
        @(negedge clk);
        rd(1'b0, 16'h0000, "rst post count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
